auth_request_arbiter: RTL
=========================

# auth_request_arbiter

- Shares the single authentication responder core between the PD and DEBUG pending-request queues.
- Scans both 8-bit pending-request vectors and picks one request by round-robin between sources, lowest slot first within a source.
- Hands the request to the core, waits for its response, and routes delivery to the owning channel once that channel is ready.
- Erases the served slot. Sits between the PD/DEBUG drivers and the auth message core.

## Interface
Parameters:
- SLOTS, 4, request slots per source
- TYPE_W, 2, bits per slot (request type; 0 = empty)
- TIMEOUT, 1024, maximum cycles to wait for the core response

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset; one clock domain
- pending_auth_request_PD  in  SLOTS*TYPE_W  PD slots; slot i = bits [TYPE_W*i+TYPE_W-1 : TYPE_W*i]
- pending_auth_request_DEBUG  in  SLOTS*TYPE_W  DEBUG slots, same layout
- PD_in_ready  in  1  PD channel can accept a response
- DEBUG_in_ready  in  1  DEBUG channel can accept a response
- grant_valid  out  1  request offered to core
- grant_src  out  1  0 = PD, 1 = DEBUG
- grant_slot  out  $clog2(SLOTS)  slot index of granted request
- grant_type  out  TYPE_W  type of granted request
- grant_accept  in  1  core takes request (valid with grant_valid)
- auth_msg_ready  in  1  core response available
- deliver_PD  out  1  one-cycle pulse: route response to PD
- deliver_DEBUG  out  1  one-cycle pulse: route response to DEBUG
- pending_auth_request_PD_erase  out  1  one-cycle pulse: clear PD slot erase_slot
- pending_auth_request_DEBUG_erase  out  1  one-cycle pulse: clear DEBUG slot erase_slot
- erase_slot  out  $clog2(SLOTS)  slot being erased
- timeout_err  out  1  one-cycle pulse: core did not answer
- busy  out  1  state != IDLE

## Operation
All outputs are registered.

States: IDLE, GRANT, WAIT, DELIVER, ERASE.
- **IDLE**
  - A source is eligible if any of its slots is non-zero.
  - If both sources are eligible, pick the source opposite last_src. Otherwise pick the eligible one.
  - Within the chosen source, pick the lowest-index non-zero slot.
  - Latch src/slot/type and go to GRANT.
- **GRANT**
  - grant_valid = 1, with grant_* held stable.
  - grant_accept = 1 → WAIT, and the timeout counter clears.
  - If the latched slot reads 0 before accept (requester withdrew), go to IDLE with no erase and last_src unchanged.
- **WAIT**
  - The counter increments each cycle.
  - auth_msg_ready = 1 → DELIVER.
  - Counter reaches TIMEOUT-1 with auth_msg_ready = 0 → ERASE, with timeout_err = 1 and no deliver.
  - If auth_msg_ready and the final count occur in the same cycle, auth_msg_ready wins.
- **DELIVER**
  - Hold until the selected source's in_ready = 1, then go to ERASE with deliver_<src> = 1.
  - The other source's in_ready is ignored.
- **ERASE** (one cycle)
  - The erase pulse for the source is asserted with erase_slot, alongside either the deliver pulse or timeout_err.
  - last_src ← src, then go to IDLE.
- The requester must clear the erased slot by the next cycle. IDLE trusts the vectors as sampled.
- Reset (reset = 0 at a clk edge), from any state:
  - state = IDLE, and all outputs are 0, including grant_* fields and erase_slot.
  - Counter = 0.
  - last_src = 1, so PD wins the first tie.

## Timing
- Request visible in IDLE at cycle N → grant_valid high in N+1.
- grant_accept sampled at M → WAIT from M+1.
- auth_msg_ready sampled at K → DELIVER at K+1.
- in_ready sampled high in DELIVER at D → deliver and erase pulses in D+1 → IDLE at D+2.
- Minimum request-to-erase latency is 4 cycles (accept and ready arriving immediately), with 1 idle cycle between consecutive grants.
- Timeout: erase and timeout_err occur exactly TIMEOUT cycles after the accept cycle.
- Pulse outputs are never high for more than one cycle. deliver_PD and deliver_DEBUG are never high together.

## Structure
- **Package auth_arb_pkg** holds:
  - the state encoding
  - SRC_PD = 0 and SRC_DEBUG = 1
  - TYPE_NONE = 0
  - default SLOTS, TYPE_W and TIMEOUT
- **Sub-module auth_slot_picker** is a combinational block: vector in → any, index and type out (lowest non-zero slot). It is instantiated once per source.
- The top level holds the FSM, latches, timeout counter and round-robin bit.

## Test plan
- **Single source, in order:** reset release, PD = 8'b00_10_00_11, DEBUG = 0 → grant src 0 / slot 0 / type 2'b11. Then accept, auth_msg_ready, PD_in_ready → deliver_PD and PD_erase with erase_slot = 0. Bench clears slot 0 → next grant is slot 2, type 2'b10.
- **Round-robin:** PD slot 1 = 2'b01 and DEBUG slot 3 = 2'b10, both persistent, core answering immediately → grant order PD, DEBUG, PD, DEBUG.
- **Timeout:** TIMEOUT = 16, accept at cycle M, no auth_msg_ready → timeout_err and the erase pulse at cycle M+16. No deliver pulse; back to IDLE.
- **Withdrawal:** PD slot 0 = 2'b01, no accept, bench clears slot 0 → grant_valid drops one cycle after the clear, with no erase and no deliver.
- **Backpressure:** DEBUG request served, DEBUG_in_ready held low for 5 cycles after auth_msg_ready → stays in DELIVER with no pulses. deliver_DEBUG occurs one cycle after in_ready rises. PD_in_ready toggling has no effect.
- **Mid-operation reset:** reset = 0 during WAIT → next cycle busy = 0 and all outputs 0. After release with both sources pending, the PD request is granted first.

Source files
------------

// File: rtl/auth_arb_pkg.sv
// Shared state encoding, source ids and default parameters for the
// authentication request arbiter.
package auth_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DELIVER = 3'd3,
    ST_ERASE   = 3'd4
  } arb_state_e;

  localparam logic SRC_PD    = 1'b0;
  localparam logic SRC_DEBUG = 1'b1;

  localparam int TYPE_NONE   = 0;

  localparam int DEF_SLOTS   = 4;
  localparam int DEF_TYPE_W  = 2;
  localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/auth_slot_picker.sv
// Combinational finder of the lowest-index non-empty slot in one
// source's pending-request vector.
module auth_slot_picker
  import auth_arb_pkg::*;
#(
  parameter  int SLOTS  = DEF_SLOTS,
  parameter  int TYPE_W = DEF_TYPE_W,
  localparam int IDX_W  = $clog2(SLOTS)
) (
  input  logic [SLOTS*TYPE_W-1:0] i_vec,
  output logic                    o_any,
  output logic [IDX_W-1:0]        o_idx,
  output logic [TYPE_W-1:0]       o_type
);

  // Walk from the top slot down so the lowest non-empty slot is the last writer.
  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    o_type = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      o_any  = o_any | (i_vec[TYPE_W*i +: TYPE_W] != TYPE_W'(TYPE_NONE));
      o_idx  = (i_vec[TYPE_W*i +: TYPE_W] != TYPE_W'(TYPE_NONE)) ? IDX_W'(i) : o_idx;
      o_type = (i_vec[TYPE_W*i +: TYPE_W] != TYPE_W'(TYPE_NONE)) ? i_vec[TYPE_W*i +: TYPE_W] : o_type;
    end
  end

endmodule

// File: rtl/auth_request_arbiter.sv
// Shares one auth responder core between the PD and DEBUG pending-request
// queues: round-robin grant, wait for response, deliver, erase the slot.
module auth_request_arbiter
  import auth_arb_pkg::*;
#(
  parameter  int SLOTS   = DEF_SLOTS,
  parameter  int TYPE_W  = DEF_TYPE_W,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IDX_W   = $clog2(SLOTS),
  localparam int VEC_W   = SLOTS * TYPE_W,
  localparam int CNT_W   = $clog2(TIMEOUT) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VEC_W-1:0]  pending_auth_request_PD,
  input  logic [VEC_W-1:0]  pending_auth_request_DEBUG,
  input  logic              PD_in_ready,
  input  logic              DEBUG_in_ready,
  output logic              grant_valid,
  output logic              grant_src,
  output logic [IDX_W-1:0]  grant_slot,
  output logic [TYPE_W-1:0] grant_type,
  input  logic              grant_accept,
  input  logic              auth_msg_ready,
  output logic              deliver_PD,
  output logic              deliver_DEBUG,
  output logic              pending_auth_request_PD_erase,
  output logic              pending_auth_request_DEBUG_erase,
  output logic [IDX_W-1:0]  erase_slot,
  output logic              timeout_err,
  output logic              busy
);

  logic              w_pd_any;
  logic              w_dbg_any;
  logic [IDX_W-1:0]  w_pd_idx;
  logic [IDX_W-1:0]  w_dbg_idx;
  logic [TYPE_W-1:0] w_pd_type;
  logic [TYPE_W-1:0] w_dbg_type;

  auth_slot_picker #(.SLOTS(SLOTS), .TYPE_W(TYPE_W)) u_pick_pd (
    .i_vec  (pending_auth_request_PD),
    .o_any  (w_pd_any),
    .o_idx  (w_pd_idx),
    .o_type (w_pd_type)
  );

  auth_slot_picker #(.SLOTS(SLOTS), .TYPE_W(TYPE_W)) u_pick_dbg (
    .i_vec  (pending_auth_request_DEBUG),
    .o_any  (w_dbg_any),
    .o_idx  (w_dbg_idx),
    .o_type (w_dbg_type)
  );

  arb_state_e        r_state,       w_state;
  logic              r_src,         w_src;
  logic [IDX_W-1:0]  r_slot,        w_slot;
  logic [TYPE_W-1:0] r_type,        w_type;
  logic              r_last_src,    w_last_src;
  logic [CNT_W-1:0]  r_cnt,         w_cnt;
  logic              r_grant_valid, w_grant_valid;
  logic              r_grant_src,   w_grant_src;
  logic [IDX_W-1:0]  r_grant_slot,  w_grant_slot;
  logic [TYPE_W-1:0] r_grant_type,  w_grant_type;
  logic              r_deliver_pd,  w_deliver_pd;
  logic              r_deliver_dbg, w_deliver_dbg;
  logic              r_erase_pd,    w_erase_pd;
  logic              r_erase_dbg,   w_erase_dbg;
  logic [IDX_W-1:0]  r_erase_slot,  w_erase_slot;
  logic              r_timeout,     w_timeout;
  logic              r_busy;
  logic              w_pick;
  logic [TYPE_W-1:0] w_cur_type;
  logic              w_src_ready;

  // Live view of the latched slot, used to notice a requester withdrawing.
  assign w_cur_type  = (r_src == SRC_DEBUG)
                     ? pending_auth_request_DEBUG[TYPE_W*int'(r_slot) +: TYPE_W]
                     : pending_auth_request_PD[TYPE_W*int'(r_slot) +: TYPE_W];
  assign w_src_ready = (r_src == SRC_DEBUG) ? DEBUG_in_ready : PD_in_ready;

  // Next-state and next-output logic; all outputs are registered from these values.
  always_comb begin
    w_state       = r_state;
    w_src         = r_src;
    w_slot        = r_slot;
    w_type        = r_type;
    w_last_src    = r_last_src;
    w_cnt         = r_cnt;
    w_pick        = SRC_PD;
    w_grant_valid = 1'b0;
    w_deliver_pd  = 1'b0;
    w_deliver_dbg = 1'b0;
    w_erase_pd    = 1'b0;
    w_erase_dbg   = 1'b0;
    w_erase_slot  = '0;
    w_timeout     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pd_any && w_dbg_any) begin
          w_pick = ~r_last_src;
        end else if (w_dbg_any) begin
          w_pick = SRC_DEBUG;
        end else begin
          w_pick = SRC_PD;
        end
        if (w_pd_any || w_dbg_any) begin
          w_src         = w_pick;
          w_slot        = (w_pick == SRC_DEBUG) ? w_dbg_idx : w_pd_idx;
          w_type        = (w_pick == SRC_DEBUG) ? w_dbg_type : w_pd_type;
          w_grant_valid = 1'b1;
          w_state       = ST_GRANT;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (grant_accept) begin
          w_state = ST_WAIT;
          w_cnt   = '0;
        end else if (w_cur_type == TYPE_W'(TYPE_NONE)) begin
          w_state = ST_IDLE;
        end else begin
          w_grant_valid = 1'b1;
        end
      end
      ST_WAIT: begin
        w_cnt = r_cnt + CNT_W'(1);
        // A response in the final cycle still beats the timeout.
        if (auth_msg_ready) begin
          w_state = ST_DELIVER;
        end else if (w_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state      = ST_ERASE;
          w_timeout    = 1'b1;
          w_erase_slot = r_slot;
          w_erase_pd   = (r_src == SRC_PD);
          w_erase_dbg  = (r_src == SRC_DEBUG);
        end else begin
          w_state = ST_WAIT;
        end
      end
      ST_DELIVER: begin
        if (w_src_ready) begin
          w_state       = ST_ERASE;
          w_deliver_pd  = (r_src == SRC_PD);
          w_deliver_dbg = (r_src == SRC_DEBUG);
          w_erase_pd    = (r_src == SRC_PD);
          w_erase_dbg   = (r_src == SRC_DEBUG);
          w_erase_slot  = r_slot;
        end else begin
          w_state = ST_DELIVER;
        end
      end
      ST_ERASE: begin
        w_last_src = r_src;
        w_state    = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
    w_grant_src  = w_grant_valid ? w_src  : 1'b0;
    w_grant_slot = w_grant_valid ? w_slot : '0;
    w_grant_type = w_grant_valid ? w_type : '0;
  end

  // State, latches, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_src         <= SRC_PD;
      r_slot        <= '0;
      r_type        <= '0;
      r_last_src    <= SRC_DEBUG;
      r_cnt         <= '0;
      r_grant_valid <= 1'b0;
      r_grant_src   <= 1'b0;
      r_grant_slot  <= '0;
      r_grant_type  <= '0;
      r_deliver_pd  <= 1'b0;
      r_deliver_dbg <= 1'b0;
      r_erase_pd    <= 1'b0;
      r_erase_dbg   <= 1'b0;
      r_erase_slot  <= '0;
      r_timeout     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_src         <= w_src;
      r_slot        <= w_slot;
      r_type        <= w_type;
      r_last_src    <= w_last_src;
      r_cnt         <= w_cnt;
      r_grant_valid <= w_grant_valid;
      r_grant_src   <= w_grant_src;
      r_grant_slot  <= w_grant_slot;
      r_grant_type  <= w_grant_type;
      r_deliver_pd  <= w_deliver_pd;
      r_deliver_dbg <= w_deliver_dbg;
      r_erase_pd    <= w_erase_pd;
      r_erase_dbg   <= w_erase_dbg;
      r_erase_slot  <= w_erase_slot;
      r_timeout     <= w_timeout;
      r_busy        <= (w_state != ST_IDLE);
    end
  end

  assign grant_valid                      = r_grant_valid;
  assign grant_src                        = r_grant_src;
  assign grant_slot                       = r_grant_slot;
  assign grant_type                       = r_grant_type;
  assign deliver_PD                       = r_deliver_pd;
  assign deliver_DEBUG                    = r_deliver_dbg;
  assign pending_auth_request_PD_erase    = r_erase_pd;
  assign pending_auth_request_DEBUG_erase = r_erase_dbg;
  assign erase_slot                       = r_erase_slot;
  assign timeout_err                      = r_timeout;
  assign busy                             = r_busy;

endmodule
